// File: rtl/md_bus_pkg.sv
// Shared constants, state encoding and address-decode helper for the md_bus master.
package md_bus_pkg;

  localparam int T_STROBE    = 8;
  localparam int T_RECOV     = 2;
  localparam int TIMEOUT_MAX = 255;

  // Byte-address bits [23:22] that select the low chip-enable region.
  localparam logic [1:0] CE_LO_SEL = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // addr is a word address, so byte-address bits [23:22] live at [22:21].
  function automatic logic is_ce_lo(input logic [22:0] addr);
    return addr[22:21] == CE_LO_SEL;
  endfunction

endpackage

// File: rtl/md_bus_master.sv
// Asynchronous-strobe bus master: one request at a time, SETUP/STROBE/RECOVER timing.
// Optional strobe timeout compiled in with MD_BUS_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// SETUP   | address (and write data) driven, strobes high
// STROBE  | strobes active; min T_STROBE cycles, then wait for dtak_n unless ce_lo region
// RECOVER | strobes high, address held; rsp_valid on last cycle
module md_bus_master
  import md_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [22:0] bus_addr,
  output logic [15:0] bus_dout,
  output logic        bus_doe,
  input  logic [15:0] bus_din,
  output logic        as_n,
  output logic        ce_lo_n,
  output logic        oe_n,
  output logic        we_lo_n,
  output logic        we_hi_n,
  input  logic        dtak_n
);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        we_q;
  logic [1:0]  be_q;
  logic        ce_lo_q;
  logic        ack_seen;
  logic        ack_now;
  logic [15:0] rdata_q;
  logic        rd_pend;
  logic        handshake;
  logic        strobe_end;
  logic        timeout_hit;
  logic        last_rec_nx;
  logic        strobe_nx;
  logic        doe_nx;

  assign req_ready = (state == IDLE);
  assign handshake = req_valid & req_ready;
  // dtak_n is sticky once seen so a short acknowledge pulse before the minimum is not lost.
  assign ack_now   = ack_seen | ~dtak_n;

`ifdef MD_BUS_TIMEOUT_EN
  logic [7:0] tmo;
  logic       err_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      tmo     <= '0;
      err_q   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (state == SETUP)
        tmo <= 8'(TIMEOUT_MAX - 1);
      else if (state == STROBE && tmo != 8'd0)
        tmo <= tmo - 8'd1;
      if (handshake)
        err_q <= 1'b0;
      else if (strobe_end && timeout_hit)
        err_q <= 1'b1;
      rsp_err <= last_rec_nx & err_q;
    end
  end

  assign timeout_hit = (state == STROBE) && !ce_lo_q && !ack_now && (tmo == 8'd0);
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    strobe_end = 1'b0;
    case (state)
      IDLE: if (handshake) state_nx = SETUP;
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = 3'(T_STROBE - 1);
      end
      STROBE: begin
        if (cnt != 3'd0) cnt_nx = cnt - 3'd1;
        strobe_end = ((cnt == 3'd0) && (ce_lo_q || ack_now)) || timeout_hit;
        if (strobe_end) begin
          state_nx = RECOVER;
          cnt_nx   = 3'(T_RECOV - 1);
        end
      end
      RECOVER: begin
        if (cnt == 3'd0) state_nx = IDLE;
        else             cnt_nx   = cnt - 3'd1;
      end
      default: state_nx = IDLE;
    endcase

    last_rec_nx = (state_nx == RECOVER) && (cnt_nx == 3'd0);
    strobe_nx   = (state_nx == STROBE);
    // Data bus stays driven through the first RECOVER cycle to cover write hold time.
    if (handshake)
      doe_nx = req_we;
    else
      doe_nx = we_q && (strobe_nx || (state_nx == SETUP) ||
                        (state == STROBE && state_nx == RECOVER));
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      ce_lo_q   <= 1'b0;
      ack_seen  <= 1'b0;
      rdata_q   <= '0;
      rd_pend   <= 1'b0;
      bus_addr  <= '0;
      bus_dout  <= '0;
      bus_doe   <= 1'b0;
      as_n      <= 1'b1;
      ce_lo_n   <= 1'b1;
      oe_n      <= 1'b1;
      we_hi_n   <= 1'b1;
      we_lo_n   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (handshake) begin
        we_q     <= req_we;
        be_q     <= req_be;
        ce_lo_q  <= is_ce_lo(req_addr);
        bus_addr <= req_addr;
        rd_pend  <= 1'b0;
        if (req_we) bus_dout <= req_wdata;
      end
      if (state == SETUP)
        ack_seen <= 1'b0;
      else if (state == STROBE && !dtak_n)
        ack_seen <= 1'b1;
      if (strobe_end && !we_q && !timeout_hit) begin
        rdata_q <= bus_din;
        rd_pend <= 1'b1;
      end
      bus_doe   <= doe_nx;
      as_n      <= !strobe_nx;
      ce_lo_n   <= !(strobe_nx && ce_lo_q);
      oe_n      <= !(strobe_nx && !we_q);
      we_hi_n   <= !(strobe_nx && we_q && be_q[1]);
      we_lo_n   <= !(strobe_nx && we_q && be_q[0]);
      rsp_valid <= last_rec_nx;
      if (last_rec_nx && rd_pend) rsp_rdata <= rdata_q;
    end
  end

endmodule

// File: tb/tb_md_bus_master.sv
// Directed bench for md_bus_master; state changes on negedge, bench drives and samples on posedge.
// Define MD_BUS_TIMEOUT_EN for both RTL and bench to exercise the timeout path.
module tb_md_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [22:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [22:0] bus_addr;
  logic [15:0] bus_dout;
  logic        bus_doe;
  logic [15:0] bus_din;
  logic        as_n, ce_lo_n, oe_n, we_lo_n, we_hi_n;
  logic        dtak_n;

  int n_assert = 0;
  int n_fail   = 0;

  md_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din),
    .as_n(as_n), .ce_lo_n(ce_lo_n), .oe_n(oe_n), .we_lo_n(we_lo_n), .we_hi_n(we_hi_n),
    .dtak_n(dtak_n)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // dly: strobe cycle index at which dtak_n goes low (0 = never).
  task automatic run_txn(input string tag, input logic we, input logic [23:0] baddr,
                         input logic [15:0] wd, input logic [1:0] be, input int dly,
                         input logic [15:0] din, input int exp_len, input logic exp_ce,
                         input logic exp_err, input logic [15:0] exp_rd);
    int as_cnt = 0, ce_cnt = 0, oe_cnt = 0, whi_cnt = 0, wlo_cnt = 0, doe_cnt = 0;
    int sidx = 0, rsp_at = 0, cyc;
    logic got_err = 1'b0;
    logic [15:0] got_rd = '0;
    @(posedge clk);
    req_valid = 1'b1; req_we = we; req_addr = baddr[23:1];
    req_wdata = wd; req_be = be; bus_din = din;
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    // Request fields scrambled after acceptance must not disturb the cycle.
    req_valid = 1'b0; req_we = ~we; req_addr = ~baddr[23:1];
    req_wdata = ~wd; req_be = ~be;
    chk({tag, "/setup_strb"}, 32'({as_n, ce_lo_n, oe_n, we_hi_n, we_lo_n}), 32'h1F);
    chk({tag, "/setup_addr"}, 32'(bus_addr), 32'(baddr[23:1]));
    if (we) chk({tag, "/setup_dout"}, 32'(bus_dout), 32'(wd));
    cyc = 1;
    while (rsp_at == 0 && cyc < 400) begin
      if (!as_n)    as_cnt++;
      if (!ce_lo_n) ce_cnt++;
      if (!oe_n)    oe_cnt++;
      if (!we_hi_n) whi_cnt++;
      if (!we_lo_n) wlo_cnt++;
      if (bus_doe)  doe_cnt++;
      if (!as_n) begin
        sidx++;
        if (dly != 0 && sidx >= dly) dtak_n = 1'b0;
        if (sidx == 1) chk({tag, "/strobe_addr"}, 32'(bus_addr), 32'(baddr[23:1]));
      end else begin
        dtak_n = 1'b1;
      end
      if (rsp_valid) begin
        rsp_at = cyc; got_err = rsp_err; got_rd = rsp_rdata;
      end
      @(posedge clk);
      cyc++;
    end
    dtak_n = 1'b1;
    chk({tag, "/as_len"},   32'(as_cnt),  32'(exp_len));
    chk({tag, "/ce_len"},   32'(ce_cnt),  exp_ce ? 32'(exp_len) : 32'd0);
    chk({tag, "/oe_len"},   32'(oe_cnt),  !we ? 32'(exp_len) : 32'd0);
    chk({tag, "/whi_len"},  32'(whi_cnt), (we && be[1]) ? 32'(exp_len) : 32'd0);
    chk({tag, "/wlo_len"},  32'(wlo_cnt), (we && be[0]) ? 32'(exp_len) : 32'd0);
    chk({tag, "/doe_len"},  32'(doe_cnt), we ? 32'(exp_len + 2) : 32'd0);
    chk({tag, "/latency"},  32'(rsp_at),  32'(exp_len + 3));
    chk({tag, "/err"},      32'(got_err), 32'(exp_err));
    chk({tag, "/rdata"},    32'(got_rd),  32'(exp_rd));
    chk({tag, "/idle"}, 32'({req_ready, rsp_valid, bus_doe, as_n}), 32'b1001);
  endtask

  initial begin
    logic as_hist[24];
    logic rv_hist[24];
    int r1, r2, last_low, next_low, gap;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; bus_din = '0; dtak_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("rst/strobes", 32'({as_n, ce_lo_n, oe_n, we_hi_n, we_lo_n}), 32'h1F);
    chk("rst/doe",     32'(bus_doe),   32'd0);
    chk("rst/addr",    32'(bus_addr),  32'd0);
    chk("rst/dout",    32'(bus_dout),  32'd0);
    chk("rst/rsp",     32'({rsp_valid, rsp_err}), 32'd0);
    chk("rst/rdata",   32'(rsp_rdata), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    chk("rst/ready", 32'(req_ready), 32'd1);

    run_txn("wr_a130f0", 1'b1, 24'hA130F0, 16'h8007, 2'b11, 1, 16'hDEAD, 8, 1'b0, 1'b0, 16'h0000);
    run_txn("rd_000200", 1'b0, 24'h000200, 16'h0000, 2'b11, 0, 16'h4E71, 8, 1'b1, 1'b0, 16'h4E71);
    run_txn("wr_be01",   1'b1, 24'h200000, 16'h1234, 2'b01, 0, 16'h5555, 8, 1'b1, 1'b0, 16'h4E71);
    run_txn("wr_be00",   1'b1, 24'h400000, 16'hA5A5, 2'b00, 3, 16'h5555, 8, 1'b0, 1'b0, 16'h4E71);
    run_txn("rd_slow",   1'b0, 24'hA10000, 16'h0000, 2'b11, 20, 16'hBEEF, 20, 1'b0, 1'b0, 16'hBEEF);
`ifdef MD_BUS_TIMEOUT_EN
    run_txn("rd_tmo",    1'b0, 24'hA10000, 16'h0000, 2'b11, 0, 16'h1111, 255, 1'b0, 1'b1, 16'hBEEF);
`endif

    // Reset in the fourth STROBE cycle of a write.
    @(posedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 23'h200000; req_wdata = 16'h7777; req_be = 2'b11;
    @(posedge clk);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    chk("rstmid/active", 32'(as_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid/strobes", 32'({as_n, ce_lo_n, oe_n, we_hi_n, we_lo_n}), 32'h1F);
    chk("rstmid/bus", 32'({bus_doe, bus_addr}), 32'd0);
    chk("rstmid/rsp", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      chk("rstmid/hold", 32'({as_n, we_lo_n, rsp_valid}), 32'b110);
    end
    rst = 1'b1;
    @(posedge clk);
    chk("rstmid/after", 32'({as_n, rsp_valid}), 32'b10);
    run_txn("rd_postrst", 1'b0, 24'h000200, 16'h0000, 2'b11, 0, 16'h0F0F, 8, 1'b1, 1'b0, 16'h0F0F);

    // Back-to-back reads with req_valid held high.
    @(posedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 23'h000000; req_be = 2'b11; bus_din = 16'h2468;
    for (int c = 0; c < 24; c++) begin
      as_hist[c] = as_n;
      rv_hist[c] = rsp_valid;
      @(posedge clk);
    end
    req_valid = 1'b0;
    r1 = -1; r2 = -1; last_low = -1; next_low = -1;
    for (int c = 0; c < 24; c++) begin
      if (rv_hist[c]) begin
        if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
      end
      if (!as_hist[c] && c <= 12) last_low = c;
      if (!as_hist[c] && c > 12 && next_low < 0) next_low = c;
    end
    gap = next_low - last_low - 1;
    chk("b2b/rsp1", 32'(r1), 32'd11);
    chk("b2b/rsp2", 32'(r2), 32'd23);
    chk("b2b/gap",  32'(gap), 32'd4);
    chk("b2b/gap_min", 32'(gap >= 3), 32'd1);
    repeat (14) @(posedge clk);
    chk("b2b/idle", 32'({req_ready, as_n}), 32'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
